// File: rtl/wb_arb_pkg.sv
// Shared types and default widths for the register-file write-port arbiter.
package wb_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned CNT_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR_A = 2'd1,
        WR_B = 2'd2
    } state_t;

endpackage

// File: rtl/wb_rr_pick.sv
// Two-way round-robin choice between the ALU and load requesters.
module wb_rr_pick (
    input  logic a_valid,
    input  logic b_valid,
    input  logic last_b,
    output logic grant_a_c,
    output logic grant_b_c
);

    // On a tie the requester not granted last wins.
    always_comb begin
        grant_a_c = a_valid & (~b_valid | last_b);
        grant_b_c = b_valid & (~a_valid | ~last_b);
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates ALU and load write-backs onto a single register-file write port.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    output logic              b_ready,
    input  logic              rf_stall,
    output logic              MUXsel2,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [CNT_W-1:0]  conflict_cnt
);

    state_t state;
    logic   last_b;
    logic   grant_a_c;
    logic   grant_b_c;

    wb_rr_pick u_pick (
        .a_valid   (a_valid),
        .b_valid   (b_valid),
        .last_b    (last_b),
        .grant_a_c (grant_a_c),
        .grant_b_c (grant_b_c)
    );

    // Grant decision, captured address and conflict counter; all frozen by rf_stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            last_b       <= 1'b1;
            MUXsel2      <= 1'b0;
            waddr        <= '0;
            conflict_cnt <= '0;
        end else if (!rf_stall) begin
            if (grant_a_c) begin
                state   <= WR_A;
                waddr   <= a_addr;
                MUXsel2 <= 1'b0;
                last_b  <= 1'b0;
            end else if (grant_b_c) begin
                state   <= WR_B;
                waddr   <= b_addr;
                MUXsel2 <= 1'b1;
                last_b  <= 1'b1;
            end else begin
                state <= IDLE;
            end
            if (a_valid && b_valid && (conflict_cnt != {CNT_W{1'b1}})) begin
                conflict_cnt <= conflict_cnt + CNT_W'(1);
            end
        end
    end

    // Stall must suppress the write in the very cycle it is raised, so it gates the state decode directly.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        we      = 1'b0;
        if (!rf_stall) begin
            a_ready = (state == WR_A);
            b_ready = (state == WR_B);
            we      = (state != IDLE) && (waddr != '0);
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a write-slot model.
module tb_wb_port_arbiter;

    localparam int unsigned AW  = 5;
    localparam int unsigned CW  = 8;
    localparam int unsigned CW2 = 2;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          a_valid  = 1'b0;
    logic          b_valid  = 1'b0;
    logic          rf_stall = 1'b0;
    logic [AW-1:0] a_addr   = '0;
    logic [AW-1:0] b_addr   = '0;

    logic          a_ready, b_ready, we, sel;
    logic [AW-1:0] waddr;
    logic [CW-1:0] cnt;
    logic          s_a_ready, s_b_ready, s_we, s_sel;
    logic [AW-1:0] s_waddr;
    logic [CW2-1:0] s_cnt;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    // Model: who owns the write slot (0 none, 1 a, 2 b), its address, and the arbitration history.
    int m_owner  = 0;
    int m_addr   = 0;
    int m_sel    = 0;
    int m_last_b = 1;
    int m_cnt    = 0;
    int m_cnt2   = 0;
    int m_win    = 0;

    int w_exp [4] = '{3, 7, 3, 7};

    wb_port_arbiter #(.ADDR_W(AW), .CNT_W(CW)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_addr(a_addr), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_ready(b_ready),
        .rf_stall(rf_stall), .MUXsel2(sel), .we(we), .waddr(waddr),
        .conflict_cnt(cnt)
    );

    wb_port_arbiter #(.ADDR_W(AW), .CNT_W(CW2)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_addr(a_addr), .a_ready(s_a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_ready(s_b_ready),
        .rf_stall(rf_stall), .MUXsel2(s_sel), .we(s_we), .waddr(s_waddr),
        .conflict_cnt(s_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = 0; m_addr = 0; m_sel = 0; m_last_b = 1; m_cnt = 0; m_cnt2 = 0;
        end else if (!rf_stall) begin
            if (a_valid && b_valid) begin
                m_cnt  = (m_cnt  < 255) ? m_cnt + 1  : 255;
                m_cnt2 = (m_cnt2 < 3)   ? m_cnt2 + 1 : 3;
                m_win  = (m_last_b != 0) ? 1 : 2;
            end else if (a_valid) m_win = 1;
            else if (b_valid)     m_win = 2;
            else                  m_win = 0;
            m_owner = m_win;
            if (m_win == 1) begin m_addr = int'(a_addr); m_sel = 0; m_last_b = 0; end
            if (m_win == 2) begin m_addr = int'(b_addr); m_sel = 1; m_last_b = 1; end
        end
    end

    task automatic compare();
        logic live;
        live = rst_n && !rf_stall;
        chk("a_ready",  32'(a_ready), 32'(live && m_owner == 1));
        chk("b_ready",  32'(b_ready), 32'(live && m_owner == 2));
        chk("we",       32'(we),      32'(live && m_owner != 0 && m_addr != 0));
        chk("waddr",    32'(waddr),   32'(m_addr));
        chk("muxsel2",  32'(sel),     32'(m_sel));
        chk("cnt",      32'(cnt),     32'(m_cnt));
        chk("s_we",     32'(s_we),    32'(we));
        chk("s_ready",  32'({s_a_ready, s_b_ready}), 32'({a_ready, b_ready}));
        chk("s_cnt",    32'(s_cnt),   32'(m_cnt2));
        chk("one_rdy",  32'(a_ready & b_ready), 32'(0));
    endtask

    always @(negedge clk) if (chk_on) compare();

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic av, input logic [AW-1:0] aa,
                         input logic bv, input logic [AW-1:0] ba, input logic st);
        a_valid = av; a_addr = aa; b_valid = bv; b_addr = ba; rf_stall = st;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0);
        step();
        step();
        rst_n  = 1'b1;
        chk_on = 1'b1;
        @(negedge clk);
        chk("rst_we", 32'(we), 32'(0));
        chk("rst_waddr", 32'(waddr), 32'(0));
        chk("rst_cnt", 32'(cnt), 32'(0));
        chk("rst_sel", 32'(sel), 32'(0));

        // Single ALU write, one-cycle latency
        step();
        drive(1, 5, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("a5_we", 32'(we), 32'(1));
        chk("a5_waddr", 32'(waddr), 32'(5));
        chk("a5_sel", 32'(sel), 32'(0));
        chk("a5_ready", 32'(a_ready), 32'(1));

        // Sustained tie alternates a,b,a,b
        step();
        do_reset();
        drive(1, 3, 1, 7, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 3) drive(0, 0, 0, 0, 0);
            @(negedge clk);
            chk("tie_waddr", 32'(waddr), 32'(w_exp[i]));
            chk("tie_sel", 32'(sel), 32'(i % 2));
            chk("tie_a_ready", 32'(a_ready), 32'(i % 2 == 0));
            chk("tie_we", 32'(we), 32'(1));
        end
        chk("tie_cnt", 32'(cnt), 32'(4));

        // Load write to r0 is accepted without a write strobe
        step();
        drive(0, 0, 1, 0, 0);
        step();
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("r0_b_ready", 32'(b_ready), 32'(1));
        chk("r0_we", 32'(we), 32'(0));

        // Stall held for three cycles while in WR_B
        step();
        drive(0, 0, 1, 9, 0);
        step();
        drive(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_we", 32'(we), 32'(0));
            chk("stall_b_ready", 32'(b_ready), 32'(0));
            chk("stall_waddr", 32'(waddr), 32'(9));
            step();
        end
        rf_stall = 1'b0;
        @(negedge clk);
        chk("unstall_we", 32'(we), 32'(1));
        chk("unstall_b_ready", 32'(b_ready), 32'(1));
        chk("unstall_waddr", 32'(waddr), 32'(9));
        chk("unstall_sel", 32'(sel), 32'(1));

        // Asynchronous reset in the middle of a write, then retry
        step();
        drive(1, 6, 0, 0, 0);
        step();
        #1 rst_n = 1'b0;
        #1;
        chk("arst_we", 32'(we), 32'(0));
        chk("arst_a_ready", 32'(a_ready), 32'(0));
        chk("arst_waddr", 32'(waddr), 32'(0));
        chk("arst_sel", 32'(sel), 32'(0));
        step();
        rst_n = 1'b1;
        step();
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("retry_we", 32'(we), 32'(1));
        chk("retry_waddr", 32'(waddr), 32'(6));
        chk("retry_a_ready", 32'(a_ready), 32'(1));

        // Counter saturation in both widths
        step();
        do_reset();
        drive(1, 1, 1, 2, 0);
        for (int i = 0; i < 300; i++) begin
            step();
            if (i == 1) chk("sat2_pre", 32'(s_cnt), 32'(2));
            if (i == 5) begin
                chk("sat2_hit", 32'(s_cnt), 32'(3));
                chk("cnt6", 32'(cnt), 32'(6));
            end
        end
        chk("sat8", 32'(cnt), 32'(255));
        chk("sat2_end", 32'(s_cnt), 32'(3));
        drive(0, 0, 0, 0, 0);
        step();

        // Random traffic with stalls and occasional resets
        for (int n = 0; n < 3000; n++) begin
            step();
            rst_n = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
            drive(($urandom_range(0, 99) < 55), AW'($urandom_range(0, 31)),
                  ($urandom_range(0, 99) < 55), AW'($urandom_range(0, 31)),
                  ($urandom_range(0, 99) < 15));
        end
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0);
        step();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
